// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV32I decode-stage controller.
// Holds opcode constants, ImmSrc/ResultSrc encodings, the ALU operation
// and controller state enums, the ID/EX control bundle type and the
// funct3/funct7 to ALU operation mapping.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {RUN, STALL, HALT} state_e;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    alu_op_e    alu_ctrl;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctrl_t;

  // funct7[5] selects SUB only for R-type; for immediates that bit is part
  // of the immediate except on the shift encodings, where it picks SRA.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt,
                                         input logic rtype);
    case (f3)
      3'b000:  return (rtype && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/main_decoder.sv
// Purely combinational RV32I main decoder.
// Ports: instr (IF/ID instruction) -> ctrl (control bundle incl. register
// indices), imm_src (immediate extender select), illegal (unknown opcode).
module main_decoder
  import ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] instr,
  output ctrl_t            ctrl,
  output logic [2:0]       imm_src,
  output logic             illegal
);

  // Only funct7[5] matters for decode; the remaining funct7 bits are immediate.
  logic unused_bits;
  assign unused_bits = ^{instr[31], instr[29:25]};

  always_comb begin
    ctrl          = '0;
    imm_src       = IMM_I;
    illegal       = 1'b0;
    ctrl.funct3   = instr[14:12];
    ctrl.rs1      = instr[19:15];
    ctrl.rs2      = instr[24:20];
    ctrl.rd       = instr[11:7];
    // Unused source fields are zeroed so they can never match a load's rd.
    case (instr[6:0])
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_ctrl   = ALU_ADD;
        ctrl.rs2        = '0;
      end
      OP_STORE: begin
        imm_src        = IMM_S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_decode(instr[14:12], instr[30], 1'b1);
      end
      OP_IALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = alu_decode(instr[14:12], instr[30], 1'b0);
        ctrl.rs2       = '0;
      end
      OP_BRANCH: begin
        imm_src       = IMM_B;
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        imm_src         = IMM_J;
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.rs1        = '0;
        ctrl.rs2        = '0;
      end
      OP_JALR: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_ctrl   = ALU_ADD;
        ctrl.rs2        = '0;
      end
      OP_LUI: begin
        imm_src         = IMM_U;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_IMM;
        ctrl.rs1        = '0;
        ctrl.rs2        = '0;
      end
      default: begin
        ctrl    = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller for the pipelined RV32I core.
// Decodes InstrD, drives ImmSrc combinationally, registers the control
// bundle into ID/EX and sequences load-use stalls, EX-resolved flushes and
// a sticky halt on illegal opcodes.
// Ports: clk, rst_n (async, active-low), InstrD, PCSrcE in;
//        ImmSrc (comb), *E control/index outputs (registered),
//        StallF/StallD/FlushD (comb), Halted (registered, sticky) out.
module decode_ctrl
  import ctrl_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int LOAD_USE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] InstrD,
  input  logic             PCSrcE,
  output logic [2:0]       ImmSrc,
  output logic             RegWriteE,
  output logic [1:0]       ResultSrcE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic [3:0]       ALUControlE,
  output logic [2:0]       Funct3E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             Halted
);

  // Extra bubbles still owed after the one inserted on detection.
  localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_CYCLES - 1);

  ctrl_t      dec_d;
  ctrl_t      idex_p1;
  logic       illegal_d;
  logic       hazard;
  logic       load_e;
  logic       halted_n;
  logic [1:0] cnt, cnt_n;
  state_e     state, state_n;

  main_decoder #(.WIDTH(WIDTH)) u_dec (
    .instr   (InstrD),
    .ctrl    (dec_d),
    .imm_src (ImmSrc),
    .illegal (illegal_d)
  );

  assign hazard = (idex_p1.result_src == RES_MEM) && (idex_p1.rd != 5'd0) &&
                  ((dec_d.rs1 == idex_p1.rd) || (dec_d.rs2 == idex_p1.rd));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    halted_n = Halted;
    load_e   = 1'b0;
    StallF   = 1'b0;
    StallD   = 1'b0;
    FlushD   = 1'b0;
    case (state)
      RUN: begin
        if (PCSrcE) begin
          FlushD = 1'b1;
        end else if (hazard) begin
          StallF = 1'b1;
          StallD = 1'b1;
          cnt_n  = CNT_INIT;
          if (CNT_INIT != 2'd0) state_n = STALL;
        end else if (illegal_d) begin
          halted_n = 1'b1;
          state_n  = HALT;
        end else begin
          load_e = 1'b1;
        end
      end
      STALL: begin
        // E holds a bubble here, so PCSrcE cannot be asserted.
        StallF = 1'b1;
        StallD = 1'b1;
        cnt_n  = cnt - 2'd1;
        if (cnt == 2'd1) state_n = RUN;
      end
      HALT: begin
        StallF = 1'b1;
        StallD = 1'b1;
      end
      default: state_n = RUN;
    endcase
  end

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= 2'd0;
      Halted  <= 1'b0;
      idex_p1 <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      Halted  <= halted_n;
      idex_p1 <= load_e ? dec_d : '0;
    end
  end

  assign RegWriteE   = idex_p1.reg_write;
  assign ResultSrcE  = idex_p1.result_src;
  assign MemWriteE   = idex_p1.mem_write;
  assign JumpE       = idex_p1.jump;
  assign BranchE     = idex_p1.branch;
  assign ALUSrcE     = idex_p1.alu_src;
  assign ALUControlE = idex_p1.alu_ctrl;
  assign Funct3E     = idex_p1.funct3;
  assign Rs1E        = idex_p1.rs1;
  assign Rs2E        = idex_p1.rs2;
  assign RdE         = idex_p1.rd;

endmodule

// File: doc/decode_ctrl.md
Name: decode_ctrl

Overview:
- Decode-stage controller for the pipelined RV32I core.
- Decodes the IF/ID instruction and drives ImmSrc combinationally to the immediate extender in the same cycle.
- Registers the control bundle into the ID/EX pipeline slot.
- Sequences load-use stalls, branch/jump flushes and a sticky halt on illegal opcodes.

Parameters:
- WIDTH, 32, instruction width.
- LOAD_USE_CYCLES, 1, bubbles inserted on a load-use hazard. Legal range 1..3, for slower data memory.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- InstrD  in  WIDTH  instruction in IF/ID.
- PCSrcE  in  1  branch/jump taken, resolved in EX.
- ImmSrc  out  3  extender select, combinational from InstrD (000 I, 001 S, 010 B, 011 J, 100 U).
- RegWriteE  out  1  registered.
- ResultSrcE  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm.
- MemWriteE  out  1  registered.
- JumpE  out  1  registered.
- BranchE  out  1  registered.
- ALUSrcE  out  1  registered.
- ALUControlE  out  4  registered.
- Funct3E  out  3  registered.
- Rs1E  out  5  registered.
- Rs2E  out  5  registered.
- RdE  out  5  registered.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID.
- FlushD  out  1  clear IF/ID.
- Halted  out  1  sticky illegal-instruction flag.

Behaviour:
- Reset is async: all E outputs 0, Halted 0, state RUN, stall counter 0. The first decode happens on the first edge after rst_n rises.
- Decode by opcode:
  - 0000011 lw: ImmSrc 000, RegWrite, ResultSrc 01, ALUSrc, ADD.
  - 0100011 sw: 001, MemWrite, ALUSrc, ADD.
  - 0110011 R-type: RegWrite, ALU op from funct3/funct7[5].
  - 0010011 I-ALU: 000, RegWrite, ALUSrc, ALU op from funct3 (funct7[5] only for shifts).
  - 1100011 branch: 010, Branch, SUB.
  - 1101111 jal: 011, Jump, RegWrite, ResultSrc 10.
  - 1100111 jalr: 000, Jump, RegWrite, ResultSrc 10, ALUSrc, ADD.
  - 0110111 lui: 100, RegWrite, ResultSrc 11.
  - Any other opcode is illegal: ImmSrc 000, all enables 0.
- Register indices:
  - Rs1/Rs2/Rd are taken from the instruction fields.
  - Rs2 is forced to 0 for I/U/J formats and Rs1 to 0 for U/J formats, so unused fields never cause false hazards.
- Bubble: every E output is 0, including RdE.
- Load-use hazard, evaluated in RUN: ResultSrcE==01, RdE!=0, and RdE matches a used Rs1D or Rs2D.
- FSM:
  - RUN:
    - PCSrcE: FlushD=1 and a bubble into E. This takes priority over everything else.
    - Else load-use: StallF=StallD=1, bubble into E, counter <= LOAD_USE_CYCLES-1. Go to STALL if the counter is nonzero, else stay in RUN.
    - Else illegal InstrD: bubble into E, Halted<=1, go to HALT.
    - Else load the decoded bundle into E.
  - STALL:
    - StallF=StallD=1, bubble into E, decrement the counter.
    - Return to RUN when the counter reaches 0. The next cycle re-evaluates the held instruction; RdE is now a bubble, so no re-detection.
    - PCSrcE in STALL cannot occur: E holds a bubble. Ignore it.
  - HALT: StallF=StallD=1, bubble into E every cycle. Only rst_n exits.
- Outputs in each state:
  - StallF/StallD/FlushD are combinational from state, hazard and PCSrcE.
  - FlushD is never asserted together with StallD.
  - ImmSrc always reflects InstrD, including while stalled.
- Reset asserted mid-stall or in HALT clears everything immediately.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams;
  - ImmSrc encodings (IMM_I..IMM_U);
  - ResultSrc encodings;
  - ALUControl enum, 4 bits: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, SLTU 1001;
  - state enum {RUN, STALL, HALT}.
- One sub-module, main_decoder: purely combinational InstrD -> control bundle + illegal flag.
- FSM, hazard compare and ID/EX register live in decode_ctrl.

Test Plan:
- Reset, then InstrD=0x00500293 (addi x5,x0,5) -> next cycle RegWriteE=1, ALUSrcE=1, ALUControlE=0000, RdE=5, ImmSrc=000. No stalls.
- lw x5,0(x1) (0x0000A283) followed by add x6,x5,x2 (0x00228333) -> one cycle with StallF=StallD=1 and bubble in E, then the add enters E with Rs1E=5. With LOAD_USE_CYCLES=3: exactly 3 bubbles.
- lw x0,0(x1) followed by add x6,x0,x2 -> no stall (RdE=0).
- beq in E with PCSrcE=1 while a load-use hazard is present in D -> FlushD=1, StallD=0, E bubble, state RUN.
- lui x7,0x12345 (0x123453B7) -> ImmSrc=100, ResultSrcE=11. jal x1,8 (0x008000EF) -> ImmSrc=011, JumpE=1, ResultSrcE=10.
- InstrD=0xFFFFFFFF -> Halted=1 the following cycle, StallF=StallD=1 held for 10+ cycles. Deassert then reassert rst_n -> Halted=0, RUN.
